// File: rtl/bus_drive_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_drive_arbiter
// Brief    : Round-robin owner selection for N shared-bus tri-state drivers,
//            with an all-disabled turnaround period between owners.
// Revision : 1.0
// ============================================================================
module bus_drive_arbiter #(
    parameter int N           = 4,
    parameter int TURN_CYCLES = 1,
    parameter int MAX_HOLD    = 0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [N-1:0]                         req,
    output logic [N-1:0]                         gnt,
    output logic [N-1:0]                         noe,
    output logic [((N > 2) ? $clog2(N) : 1)-1:0] owner,
    output logic                                 busy,
    output logic                                 preempt
);
    localparam int              c_OW        = (N > 2) ? $clog2(N) : 1;
    localparam int              c_HW        = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [c_HW-1:0] c_HOLD_LAST = (MAX_HOLD > 0) ? c_HW'(MAX_HOLD - 1) : '0;
    localparam logic [3:0]      c_TURN_LAST = 4'(TURN_CYCLES - 1);
    localparam logic [c_OW-1:0] c_LAST_IDX  = c_OW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_TURN  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [N-1:0]      gnt_q, gnt_d;
    logic [N-1:0]      noe_q, noe_d;
    logic [c_OW-1:0]   owner_q, owner_d;
    logic              busy_q, busy_d;
    logic              preempt_q, preempt_d;
    logic [c_OW-1:0]   ptr_q, ptr_d;
    logic [c_HW-1:0]   hold_q, hold_d;
    logic [3:0]        turn_q, turn_d;

    logic              w_win_found;
    logic [c_OW-1:0]   w_win_idx;
    logic [N-1:0]      w_win_oh;
    int                w_best_dist;
    int                w_dist;
    logic              w_owner_req;
    logic              w_others_req;
    logic              w_arbitrate;
    logic              w_leave;

    // Winner is the requester closest to ptr_q going upward with wrap.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_win_oh    = '0;
        w_best_dist = N;
        w_dist      = 0;
        for (int i = 0; i < N; i++) begin
            w_dist = i - int'(ptr_q);
            if (w_dist < 0) begin
                w_dist = w_dist + N;
            end
            if (req[i] && (w_dist < w_best_dist)) begin
                w_best_dist = w_dist;
                w_win_found = 1'b1;
                w_win_idx   = c_OW'(i);
                w_win_oh    = '0;
                w_win_oh[i] = 1'b1;
            end
        end
    end

    assign w_owner_req  = |(req & gnt_q);
    assign w_others_req = |(req & ~gnt_q);

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        hold_d      = hold_q;
        turn_d      = turn_q;
        preempt_d   = 1'b0;
        w_arbitrate = 1'b0;
        w_leave     = 1'b0;

        case (state_q)
            S_IDLE: w_arbitrate = 1'b1;
            S_DRIVE: begin
                // Saturating at the limit keeps preemption armed for late arrivals.
                if (hold_q != c_HOLD_LAST) begin
                    hold_d = hold_q + 1'b1;
                end
                if (!w_owner_req) begin
                    w_leave = 1'b1;
                end else if ((MAX_HOLD != 0) && (hold_q == c_HOLD_LAST) && w_others_req) begin
                    w_leave   = 1'b1;
                    preempt_d = 1'b1;
                end
            end
            S_TURN: begin
                if (turn_q == '0) begin
                    w_arbitrate = 1'b1;
                end else begin
                    turn_d = turn_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (w_leave) begin
            state_d = S_TURN;
            gnt_d   = '0;
            turn_d  = c_TURN_LAST;
        end

        if (w_arbitrate) begin
            if (w_win_found) begin
                state_d = S_DRIVE;
                gnt_d   = w_win_oh;
                owner_d = w_win_idx;
                ptr_d   = (w_win_idx == c_LAST_IDX) ? '0 : w_win_idx + 1'b1;
                hold_d  = '0;
            end else begin
                state_d = S_IDLE;
            end
        end

        noe_d  = ~gnt_d;
        busy_d = |gnt_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            gnt_q     <= '0;
            noe_q     <= '1;
            owner_q   <= '0;
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
            ptr_q     <= '0;
            hold_q    <= '0;
            turn_q    <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            noe_q     <= noe_d;
            owner_q   <= owner_d;
            busy_q    <= busy_d;
            preempt_q <= preempt_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            turn_q    <= turn_d;
        end
    end

    assign gnt     = gnt_q;
    assign noe     = noe_q;
    assign owner   = owner_q;
    assign busy    = busy_q;
    assign preempt = preempt_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_drive_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_drive_arbiter
// Brief    : Three arbiter configurations driven in parallel and scored against
//            a cycle-level reference model.
// Revision : 1.0
// ============================================================================
module tb_bus_drive_arbiter;

    typedef struct packed {
        logic [3:0] gnt;
        logic [3:0] noe;
        logic [1:0] owner;
        logic       busy;
        logic       preempt;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = 4'b0;

    logic [3:0] gnt0, gnt1, gnt2, noe0, noe1, noe2;
    logic [1:0] owner0, owner1, owner2;
    logic       busy0, busy1, busy2, pre0, pre1, pre2;

    int checks = 0;
    int errors = 0;

    logic [35:0] exp_q [$];

    // Reference model state, one slot per configuration.
    bit         has   [3];
    logic [1:0] cur   [3];
    logic [1:0] last  [3];
    logic [1:0] start [3];
    int         dead  [3];
    int         tenure[3];
    bit         pre   [3];

    logic [3:0] rnd_req;
    logic [3:0] flip;

    always #5 clk = ~clk;

    bus_drive_arbiter #(.N(4), .TURN_CYCLES(1), .MAX_HOLD(0)) u_dut0 (
        .clk(clk), .reset(reset), .req(req), .gnt(gnt0), .noe(noe0),
        .owner(owner0), .busy(busy0), .preempt(pre0));
    bus_drive_arbiter #(.N(4), .TURN_CYCLES(3), .MAX_HOLD(0)) u_dut1 (
        .clk(clk), .reset(reset), .req(req), .gnt(gnt1), .noe(noe1),
        .owner(owner1), .busy(busy1), .preempt(pre1));
    bus_drive_arbiter #(.N(4), .TURN_CYCLES(1), .MAX_HOLD(4)) u_dut2 (
        .clk(clk), .reset(reset), .req(req), .gnt(gnt2), .noe(noe2),
        .owner(owner2), .busy(busy2), .preempt(pre2));

    function automatic int cfg_turn(input int i);
        return (i == 1) ? 3 : 1;
    endfunction

    function automatic int cfg_hold(input int i);
        return (i == 2) ? 4 : 0;
    endfunction

    function automatic obs_t act(input int i);
        obs_t a;
        a = '0;
        case (i)
            0: a = '{gnt: gnt0, noe: noe0, owner: owner0, busy: busy0, preempt: pre0};
            1: a = '{gnt: gnt1, noe: noe1, owner: owner1, busy: busy1, preempt: pre1};
            default: a = '{gnt: gnt2, noe: noe2, owner: owner2, busy: busy2, preempt: pre2};
        endcase
        return a;
    endfunction

    // Advance every model by one clock edge with the inputs sampled at that edge.
    task automatic model_step(input logic [3:0] r, input logic rs);
        logic [35:0] pk;
        pk = '0;
        for (int i = 0; i < 3; i++) begin
            obs_t       e;
            logic [1:0] w;
            if (rs) begin
                has[i] = 0; cur[i] = 2'd0; last[i] = 2'd0; start[i] = 2'd0;
                dead[i] = 0; tenure[i] = 0; pre[i] = 0;
            end else if (has[i]) begin
                tenure[i] = tenure[i] + 1;
                pre[i] = 0;
                if (!r[cur[i]]) begin
                    has[i] = 0;
                    dead[i] = cfg_turn(i);
                end else if (cfg_hold(i) != 0 && tenure[i] >= cfg_hold(i) &&
                             (r & ~(4'b0001 << cur[i])) != 4'b0) begin
                    has[i] = 0;
                    pre[i] = 1;
                    dead[i] = cfg_turn(i);
                end
            end else begin
                pre[i] = 0;
                if (dead[i] > 1) begin
                    dead[i] = dead[i] - 1;
                end else begin
                    dead[i] = 0;
                    for (int k = 0; k < 4; k++) begin
                        w = start[i] + 2'(k);
                        if (!has[i] && r[w]) begin
                            has[i] = 1; cur[i] = w; last[i] = w;
                            start[i] = w + 2'd1; tenure[i] = 0;
                        end
                    end
                end
            end
            e.gnt     = has[i] ? (4'b0001 << cur[i]) : 4'b0000;
            e.noe     = ~e.gnt;
            e.owner   = last[i];
            e.busy    = has[i];
            e.preempt = pre[i];
            pk[i*12 +: 12] = e;
        end
        exp_q.push_back(pk);
    endtask

    task automatic drive(input logic [3:0] r, input logic rs);
        req = r;
        reset = rs;
        @(posedge clk);
        model_step(r, rs);
        #1;
    endtask

    task automatic drive_n(input logic [3:0] r, input int n);
        for (int c = 0; c < n; c++) drive(r, 1'b0);
    endtask

    // Monitor: outputs are valid every cycle, so one expectation per edge.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                logic [35:0] pk;
                pk = exp_q.pop_front();
                for (int i = 0; i < 3; i++) begin
                    obs_t e, a;
                    e = obs_t'(pk[i*12 +: 12]);
                    a = act(i);
                    checks++;
                    if (a !== e) begin
                        errors++;
                        $display("FAIL outputs inst%0d @%0t actual gnt=%b noe=%b owner=%0d busy=%b preempt=%b required gnt=%b noe=%b owner=%0d busy=%b preempt=%b",
                                 i, $time, a.gnt, a.noe, a.owner, a.busy, a.preempt,
                                 e.gnt, e.noe, e.owner, e.busy, e.preempt);
                    end
                    checks++;
                    if (!$onehot0(a.gnt)) begin
                        errors++;
                        $display("FAIL onehot inst%0d @%0t actual gnt=%b required at most one bit set", i, $time, a.gnt);
                    end
                end
            end
        end
    end

    initial begin
        // Reset with every request asserted, then release into round-robin.
        drive(4'b1111, 1'b1);
        drive(4'b1111, 1'b1);
        for (int c = 0; c < 24; c++) begin
            logic [3:0] r;
            r = 4'b1111;
            if (has[0] && tenure[0] >= 2) r[cur[0]] = 1'b0;
            drive(r, 1'b0);
        end

        // Single requester.
        drive_n(4'b0000, 6);
        drive_n(4'b0100, 5);
        drive_n(4'b0000, 5);

        // Owner 0 releases while index 2 waits.
        drive_n(4'b0001, 3);
        drive_n(4'b0101, 2);
        drive_n(4'b0100, 8);
        drive_n(4'b0000, 5);

        // Two requesters held continuously.
        drive_n(4'b0011, 22);
        drive_n(4'b0000, 5);

        // Reset in the middle of a tenure, then in the middle of a turnaround.
        drive_n(4'b0100, 3);
        drive(4'b0100, 1'b1);
        drive_n(4'b0010, 3);
        drive(4'b0000, 1'b0);
        drive(4'b0000, 1'b1);
        drive_n(4'b1000, 4);

        // Randomised requests with sticky bits and rare resets.
        rnd_req = 4'b0;
        for (int c = 0; c < 3000; c++) begin
            flip = 4'b0;
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 5) == 0) flip = flip | (4'b0001 << b);
            end
            rnd_req = rnd_req ^ flip;
            drive(rnd_req, ($urandom_range(0, 299) == 0));
        end
        drive_n(4'b0000, 2);

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual pending=%0d required pending=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
